chacha20_stream_xor: RTL
========================

# chacha20_stream_xor

Keystream consumer for the ChaCha20 datapath: it sits downstream of `chacha20_top`, issues block requests to it, buffers the returned 512-bit keystream block, and XORs it word-by-word into a 32-bit data stream. The block counter auto-increments at each block boundary, so callers see an unbounded encrypt/decrypt pipe. Encryption and decryption are the same operation.

## Interface

Parameters:
- `WORD_W`, 32: data word width; fixed at 32, and any other value is a synthesis error.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-low reset.
- `init` in 1: one-cycle pulse that starts a session; sampled only in IDLE or ERR.
- `key` in 256: session key; latched on `init`.
- `nonce` in 96: session nonce; latched on `init`.
- `counter_init` in 32: first block counter; latched on `init`.
- `in_data` in 32: plaintext or ciphertext word.
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: the current input word is the final word of the message.
- `in_ready` out 1: this block accepts the input word.
- `out_data` out 32: `in_data` XOR keystream word.
- `out_valid` out 1: `out_data` is valid.
- `out_last` out 1: registered copy of `in_last`.
- `out_ready` in 1: downstream accepts `out_data`.
- `core_start` out 1: block request to `chacha20_top`.
- `core_key` out 256: latched key.
- `core_nonce` out 96: latched nonce.
- `core_counter` out 32: counter for the requested block.
- `core_keystream` in 512: keystream block from the core.
- `core_done` in 1: the core's result is valid.
- `busy` out 1: high when the state is not IDLE and not ERR.
- `ctr_wrap` out 1: sticky error flag; the counter would exceed 0xFFFFFFFF.

## Operation

- States: IDLE, REQ, WAIT, STREAM, ERR.
- **IDLE, on `init`:**
  - Latch `key`, `nonce`, `counter_init` into `core_key`, `core_nonce`, `core_counter`.
  - Clear `ctr_wrap`.
  - Go to REQ.
- **REQ:**
  - `core_start`=1 for exactly one cycle.
  - Go to WAIT.
- **WAIT:**
  - On the first cycle with `core_done`=1, capture `core_keystream` into a 512-bit buffer and set `idx`=0.
  - Go to STREAM.
  - `core_done` may be a pulse or a level; only the first sample in WAIT counts.
- **STREAM:**
  - `in_ready` = (!`out_valid` || `out_ready`).
  - On an input handshake:
    - `out_data` <= `in_data` ^ buf[32*idx +: 32], so word 0 = bits [31:0].
    - `out_valid` <= 1.
    - `out_last` <= `in_last`.
    - `idx` <= `idx`+1.
  - On an output handshake with no new input: `out_valid` <= 0.
- **End of message:** a handshake with `in_last`=1 goes to IDLE. Unused buffered keystream is discarded and the counter is not advanced.
- **Block boundary:** a handshake with `idx`=15 and `in_last`=0 does one of the following:
  - If `core_counter`≠0xFFFFFFFF: `core_counter` <= `core_counter`+1 (modulo 2^32), then go to REQ.
  - If `core_counter`=0xFFFFFFFF: set `ctr_wrap`=1 and go to ERR. No new `core_start` is issued.
- **ERR:**
  - `in_ready`=0.
  - A pending output word still drains.
  - Only `init` or `reset` exits ERR.
- `init` outside IDLE/ERR is ignored.
- `in_ready`=0 in IDLE, REQ, WAIT and ERR.
- `out_valid` must not drop while `out_ready`=0, and `out_data`/`out_last` stay stable during that time.
- `in_last` and `in_ready` on the same cycle as `idx`=15 count as end of message; no refill is issued.

## Timing

- Reset values (`reset`=0 at a clock edge) are all zero:
  - state=IDLE.
  - `core_start`, `out_valid`, `out_last`, `busy`, `ctr_wrap` = 0.
  - `out_data`, `core_counter`, `core_key`, `core_nonce`, `idx`, buffer = 0.
- Reset mid-operation:
  - Abandons the session immediately.
  - An outstanding `core_done` that arrives afterwards is ignored, because the state is IDLE.
- Start-up latency:
  - `init` at cycle T gives `core_start` at T+1.
  - The block is in WAIT from T+2.
  - `core_done` at cycle D gives STREAM and `in_ready` at D+1.
- Throughput: one word per cycle within a block when `out_ready`=1.
- Refill bubble per 16 words: 2 cycles plus the core latency (REQ, then WAIT through `core_done`).
- Data path: one register stage, so `out_valid` follows the input handshake by 1 cycle.
- `busy` is registered from the state.

## Test plan

- **RFC 8439 §2.3.2 vector:**
  - Stimulus: key 00010203…1E1F, nonce 000000090000004A00000000, `counter_init`=1, 16 zero words with `in_last` on word 15, real `chacha20_top` attached.
  - Required: `out_data` = e4e7f110, 15593bd1, 1fdd0f50, …, e883d0cb, 4e3c50a2.
  - Required: return to IDLE, `core_start` pulsed exactly once.
- **Round trip:**
  - Stimulus: encrypt 40 random words, re-`init` with the same key/nonce/counter, feed the ciphertext back in.
  - Required: output equals the original plaintext.
  - Required: `core_counter` seen at the three `core_start` pulses = 1, 2, 3.
- **Backpressure:**
  - Stimulus: drive `out_ready` from a random 30% pattern over 20 words.
  - Required: no lost or duplicated words, `out_data` stable while stalled, same result as the unstalled run.
- **Counter wrap:**
  - Stimulus: `counter_init`=FFFFFFFF, 17 words.
  - Required: the first 16 words pass; `ctr_wrap`=1 after word 15; word 16 is never accepted (`in_ready`=0); `core_start` is not re-pulsed.
  - Then: a fresh `init` clears `ctr_wrap`.
- **Reset mid-block:**
  - Stimulus: drop `reset` for 1 cycle after word 5.
  - Required: all outputs are 0 and the state is IDLE; a late `core_done` pulse causes no `out_valid`.
- **Early last / ignored init:**
  - Stimulus: `in_last` on word 3, plus an `init` pulse during STREAM.
  - Required: return to IDLE after word 3; the `init` is ignored, so the latched key and counter are unchanged.

Source files
------------

// File: rtl/chacha20_stream_xor.sv
`default_nettype none
// ============================================================================
// Module      : chacha20_stream_xor
// Description : ChaCha20 keystream consumer. Requests 512-bit keystream
//               blocks from the ChaCha20 core, buffers one block and XORs it
//               word-by-word into a 32-bit ready/valid data stream. The block
//               counter advances automatically at every 16-word boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module chacha20_stream_xor #(
    parameter int WORD_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [255:0]       key,
    input  logic [95:0]        nonce,
    input  logic [31:0]        counter_init,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               core_start,
    output logic [255:0]       core_key,
    output logic [95:0]        core_nonce,
    output logic [31:0]        core_counter,
    input  logic [511:0]       core_keystream,
    input  logic               core_done,
    output logic               busy,
    output logic               ctr_wrap
);

    // The keystream buffer is sliced in 32-bit words; other widths cannot work.
    if (WORD_W != 32) begin : g_width_check
        $error("chacha20_stream_xor: WORD_W must be 32");
    end

    localparam logic [31:0] c_CTR_MAX  = 32'hFFFF_FFFF;
    localparam logic [3:0]  c_LAST_IDX = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t              state_q,   state_d;
    logic [255:0]        key_q,     key_d;
    logic [95:0]         nonce_q,   nonce_d;
    logic [31:0]         ctr_q,     ctr_d;
    logic [511:0]        buf_q,     buf_d;
    logic [3:0]          idx_q,     idx_d;
    logic [WORD_W-1:0]   odata_q,   odata_d;
    logic                ovalid_q,  ovalid_d;
    logic                olast_q,   olast_d;
    logic                wrap_q,    wrap_d;
    logic                busy_q,    busy_d;

    logic                w_in_ready;
    logic                w_in_hs;
    logic                w_out_hs;
    logic [WORD_W-1:0]   w_ks_word;

    // A new word may enter whenever the output register is empty or draining.
    assign w_in_ready = (state_q == S_STREAM) && (!ovalid_q || out_ready);
    assign w_in_hs    = in_valid && w_in_ready;
    assign w_out_hs   = ovalid_q && out_ready;
    assign w_ks_word  = buf_q[{idx_q, 5'd0} +: WORD_W];

    // Next-state, session registers and output-register update.
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        nonce_d  = nonce_q;
        ctr_d    = ctr_q;
        buf_d    = buf_q;
        idx_d    = idx_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        olast_d  = olast_q;
        wrap_d   = wrap_q;

        // A pending word drains in every state; a fresh input overrides below.
        if (w_out_hs) begin
            ovalid_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_ERR: begin
                if (init) begin
                    key_d   = key;
                    nonce_d = nonce;
                    ctr_d   = counter_init;
                    wrap_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    buf_d   = core_keystream;
                    idx_d   = 4'd0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_in_hs) begin
                    odata_d  = in_data ^ w_ks_word;
                    ovalid_d = 1'b1;
                    olast_d  = in_last;
                    idx_d    = idx_q + 4'd1;
                    if (in_last) begin
                        // Remaining keystream is thrown away; counter untouched.
                        state_d = S_IDLE;
                    end else if (idx_q == c_LAST_IDX) begin
                        if (ctr_q != c_CTR_MAX) begin
                            ctr_d   = ctr_q + 32'd1;
                            state_d = S_REQ;
                        end else begin
                            wrap_d  = 1'b1;
                            state_d = S_ERR;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_ERR);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            nonce_q  <= '0;
            ctr_q    <= '0;
            buf_q    <= '0;
            idx_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
            wrap_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            nonce_q  <= nonce_d;
            ctr_q    <= ctr_d;
            buf_q    <= buf_d;
            idx_q    <= idx_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
            wrap_q   <= wrap_d;
            busy_q   <= busy_d;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_data     = odata_q;
    assign out_valid    = ovalid_q;
    assign out_last     = olast_q;
    assign core_start   = (state_q == S_REQ);
    assign core_key     = key_q;
    assign core_nonce   = nonce_q;
    assign core_counter = ctr_q;
    assign busy         = busy_q;
    assign ctr_wrap     = wrap_q;

endmodule
`default_nettype wire
